// File: rtl/link_test_seq.sv
// Link self-test sequencer: sends LFSR packets to the Encoder and checks the Decoder echoes.
// Build option LINK_TEST_STOP_ON_FAIL_EN ends a run at its first failing packet.
module link_test_seq #(
  parameter int N_PKT     = 8,
  parameter int N_TESTS   = 256,
  parameter int TIMEOUT   = 2000000,
  parameter int MAX_RETRY = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go,
  input  logic             abort,
  input  logic [31:0]      lfsr_data,
  output logic             lfsr_en,
  output logic [N_PKT-1:0] enc_data,
  output logic             enc_start,
  input  logic             enc_avail,
  input  logic [N_PKT-1:0] dec_data,
  input  logic             dec_avail,
  input  logic             dec_error,
  output logic             dec_read,
  output logic             busy,
  output logic             done,
  output logic [15:0]      pass_cnt,
  output logic [15:0]      fail_cnt,
  output logic [15:0]      timeout_cnt,
  output logic [N_PKT-1:0] fail_pkt
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam int IDX_W = $clog2(N_TESTS + 1);
  localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_TESTS - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

`ifdef LINK_TEST_STOP_ON_FAIL_EN
  localparam bit STOP_ON_FAIL = 1'b1;
`else
  localparam bit STOP_ON_FAIL = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SEND,
    WAIT_RX,
    NEXT,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic [N_PKT-1:0]   pkt_q, pkt_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [RTY_W-1:0]   retry_q, retry_d;
  logic [15:0]        pass_q, pass_d;
  logic [15:0]        fail_q, fail_d;
  logic [15:0]        tmo_q, tmo_d;
  logic [N_PKT-1:0]   fail_pkt_q, fail_pkt_d;
  logic               fail_seen_q, fail_seen_d;
  logic               lfsr_en_q, lfsr_en_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               active;

  // Only the low N_PKT bits of the LFSR word form a packet.
  generate
    if (N_PKT < 32) begin : g_lfsr_hi
      logic unused_lfsr_hi;
      assign unused_lfsr_hi = ^lfsr_data[31:N_PKT];
    end
  endgenerate

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign active    = (state_q != IDLE) && (state_q != DONE);
  assign enc_start = (state_q == SEND) && enc_avail && !abort;
  // Any Decoder packet is consumed; only one seen in WAIT_RX is scored.
  assign dec_read  = rst_n && dec_avail;

  always_comb begin
    state_d     = state_q;
    pkt_d       = pkt_q;
    timer_d     = timer_q;
    idx_d       = idx_q;
    retry_d     = retry_q;
    pass_d      = pass_q;
    fail_d      = fail_q;
    tmo_d       = tmo_q;
    fail_pkt_d  = fail_pkt_q;
    fail_seen_d = fail_seen_q;
    lfsr_en_d   = 1'b0;

    if (active && abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (go) begin
            pass_d      = '0;
            fail_d      = '0;
            tmo_d       = '0;
            fail_pkt_d  = '0;
            fail_seen_d = 1'b0;
            idx_d       = '0;
            retry_d     = '0;
            lfsr_en_d   = 1'b1;
            state_d     = LOAD;
          end
        end
        LOAD: begin
          pkt_d   = lfsr_data[N_PKT-1:0];
          state_d = SEND;
        end
        SEND: begin
          if (enc_avail) begin
            timer_d = '0;
            state_d = WAIT_RX;
          end
        end
        WAIT_RX: begin
          timer_d = timer_q + TMR_W'(1);
          // An echo arriving on the expiry cycle still counts as an echo.
          if (dec_avail) begin
            state_d = NEXT;
            if ((dec_data == pkt_q) && !dec_error) begin
              pass_d = sat_inc(pass_q);
            end else begin
              fail_d      = sat_inc(fail_q);
              fail_seen_d = 1'b1;
              if (!fail_seen_q) fail_pkt_d = dec_data;
              if (STOP_ON_FAIL) state_d = DONE;
            end
          end else if (timer_q == TMR_LAST) begin
            tmo_d = sat_inc(tmo_q);
            if (retry_q < RTY_MAX) begin
              retry_d = retry_q + RTY_W'(1);
              state_d = SEND;
            end else begin
              fail_d      = sat_inc(fail_q);
              fail_seen_d = 1'b1;
              state_d     = STOP_ON_FAIL ? DONE : NEXT;
            end
          end
        end
        NEXT: begin
          retry_d = '0;
          if (idx_q == IDX_LAST) begin
            state_d = DONE;
          end else begin
            idx_d     = idx_q + IDX_W'(1);
            lfsr_en_d = 1'b1;
            state_d   = LOAD;
          end
        end
        DONE: begin
          if (!go) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE) && (state_d != DONE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pkt_q       <= '0;
      timer_q     <= '0;
      idx_q       <= '0;
      retry_q     <= '0;
      pass_q      <= '0;
      fail_q      <= '0;
      tmo_q       <= '0;
      fail_pkt_q  <= '0;
      fail_seen_q <= 1'b0;
      lfsr_en_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pkt_q       <= pkt_d;
      timer_q     <= timer_d;
      idx_q       <= idx_d;
      retry_q     <= retry_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      tmo_q       <= tmo_d;
      fail_pkt_q  <= fail_pkt_d;
      fail_seen_q <= fail_seen_d;
      lfsr_en_q   <= lfsr_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign lfsr_en     = lfsr_en_q;
  assign enc_data    = pkt_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass_cnt    = pass_q;
  assign fail_cnt    = fail_q;
  assign timeout_cnt = tmo_q;
  assign fail_pkt    = fail_pkt_q;

endmodule

// File: tb/tb_link_test_seq.sv
// Scoreboard bench for link_test_seq: loopback echo model, LFSR model and a per-run outcome model.
// Expected results follow LINK_TEST_STOP_ON_FAIL_EN when it is defined for the build.
module tb_link_test_seq;

  localparam int N_PKT     = 8;
  localparam int N_TESTS   = 4;
  localparam int TIMEOUT   = 100;
  localparam int MAX_RETRY = 3;
  localparam int MAX_ATT   = N_TESTS * (MAX_RETRY + 1);

`ifdef LINK_TEST_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  typedef struct packed {
    logic       drop;
    logic [7:0] delay;
    logic [7:0] mask;
    logic       err;
  } act_t;

  typedef struct {
    int         pass;
    int         fail;
    int         tmo;
    logic [7:0] fpkt;
    int         starts;
    int         loads;
  } res_t;

  logic             clk;
  logic             rst_n;
  logic             go;
  logic             abort;
  logic [31:0]      lfsr_data;
  logic             lfsr_en;
  logic [N_PKT-1:0] enc_data;
  logic             enc_start;
  logic             enc_avail;
  logic [N_PKT-1:0] dec_data;
  logic             dec_avail;
  logic             dec_error;
  logic             dec_read;
  logic             busy;
  logic             done;
  logic [15:0]      pass_cnt;
  logic [15:0]      fail_cnt;
  logic [15:0]      timeout_cnt;
  logic [N_PKT-1:0] fail_pkt;

  int total = 0;
  int bad   = 0;

  act_t        act_q[$];
  act_t        act_arr[0:MAX_ATT-1];
  logic [7:0]  exp_pkt_q[$];
  res_t        exp_res_q[$];
  logic [31:0] words[0:7];
  int          lfsr_idx  = 0;
  int          start_cnt = 0;
  int          lfsr_cnt  = 0;
  int          read_cnt  = 0;
  bit          avail_rand = 1'b1;
  logic        done_prev  = 1'b0;

  link_test_seq #(
    .N_PKT(N_PKT), .N_TESTS(N_TESTS), .TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .abort(abort),
    .lfsr_data(lfsr_data), .lfsr_en(lfsr_en),
    .enc_data(enc_data), .enc_start(enc_start), .enc_avail(enc_avail),
    .dec_data(dec_data), .dec_avail(dec_avail), .dec_error(dec_error), .dec_read(dec_read),
    .busy(busy), .done(done),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .timeout_cnt(timeout_cnt), .fail_pkt(fail_pkt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: walk tests and attempts, decide each packet's outcome from its echo action.
  task automatic modelRun();
    res_t r;
    int att;
    bit resolved, failed;
    logic [7:0] p, rx;
    r.pass = 0; r.fail = 0; r.tmo = 0; r.fpkt = 8'h00; r.starts = 0; r.loads = 0;
    att = 0;
    for (int i = 0; i < N_TESTS; i++) begin
      p = words[i][7:0];
      r.loads++;
      resolved = 1'b0;
      failed = 1'b0;
      for (int t = 0; t <= MAX_RETRY && !resolved; t++) begin
        exp_pkt_q.push_back(p);
        r.starts++;
        if (!act_arr[att].drop) begin
          resolved = 1'b1;
          rx = p ^ act_arr[att].mask;
          if (rx == p && !act_arr[att].err) begin
            r.pass++;
          end else begin
            if (r.fail == 0) r.fpkt = rx;
            r.fail++;
            failed = 1'b1;
          end
        end else begin
          r.tmo++;
        end
        att++;
      end
      if (!resolved) begin
        r.fail++;
        failed = 1'b1;
      end
      if (STOP && failed) break;
    end
    exp_res_q.push_back(r);
  endtask

  task automatic newWords(input bit force_a5);
    for (int k = 0; k < 8; k++) words[k] = $urandom;
    words[0][0] = 1'b1;
    if (force_a5) words[2][7:0] = 8'hA5;
    lfsr_idx  = 0;
    lfsr_data = words[0];
  endtask

  // mode 0 clean, 1 bit0 flip on test 2, 2 no echo, 3 echo on expiry cycle, 4 random
  task automatic applyStimulus(input int mode);
    int cyc;
    act_t a;
    @(posedge clk); #1;
    newWords(mode == 1);
    act_q.delete();
    for (int k = 0; k < MAX_ATT; k++) begin
      a.drop = 1'b0; a.delay = 8'd50; a.mask = 8'h00; a.err = 1'b0;
      case (mode)
        1: a.mask = (k == 2) ? 8'h01 : 8'h00;
        2: a.drop = 1'b1;
        3: a.delay = 8'(TIMEOUT);
        4: begin
          a.drop = ($urandom_range(0, 3) == 0);
          case ($urandom_range(0, 5))
            0: a.delay = 8'd1;
            1: a.delay = 8'(TIMEOUT);
            2: a.delay = 8'(TIMEOUT - 1);
            default: a.delay = 8'($urandom_range(1, TIMEOUT));
          endcase
          a.mask = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
          a.err  = ($urandom_range(0, 7) == 0);
        end
        default: ;
      endcase
      act_arr[k] = a;
      act_q.push_back(a);
    end
    modelRun();
    start_cnt = 0;
    lfsr_cnt  = 0;
    go = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("load_lfsr_en", 32'(lfsr_en), 32'd1);
    checkOutput("load_busy", 32'(busy), 32'd1);
    checkOutput("go_clears_counts", {pass_cnt, fail_cnt | timeout_cnt}, 32'd0);
    checkOutput("go_clears_fail_pkt", 32'(fail_pkt), 32'd0);
    cyc = 0;
    while (!done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("run_finished", 32'(done), 32'd1);
    @(posedge clk); #1;
    go = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("idle_after_done", 32'(done), 32'd0);
    checkOutput("pkt_queue_drained", 32'(exp_pkt_q.size()), 32'd0);
    exp_pkt_q.delete();
    exp_res_q.delete();
  endtask

  task automatic runAbort();
    int cyc, read_before;
    act_t a;
    @(posedge clk); #1;
    newWords(1'b0);
    act_q.delete();
    a.drop = 1'b0; a.delay = 8'd50; a.mask = 8'h00; a.err = 1'b0;
    for (int k = 0; k < 2; k++) act_q.push_back(a);
    exp_pkt_q.push_back(words[0][7:0]);
    exp_pkt_q.push_back(words[1][7:0]);
    start_cnt = 0;
    go = 1'b1;
    cyc = 0;
    while (start_cnt < 2 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("abort_reached_test1", 32'(start_cnt), 32'd2);
    read_before = read_cnt;
    repeat (10) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    go = 1'b0;
    @(negedge clk);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_pass_held", 32'(pass_cnt), 32'd1);
    repeat (60) @(negedge clk);
    checkOutput("stale_echo_flushed", 32'(read_cnt - read_before), 32'd1);
    checkOutput("flush_pass_held", 32'(pass_cnt), 32'd1);
    checkOutput("flush_fail_held", 32'(fail_cnt), 32'd0);
    checkOutput("abort_pkt_queue", 32'(exp_pkt_q.size()), 32'd0);
    exp_pkt_q.delete();
  endtask

  task automatic runResetTest();
    @(posedge clk); #1;
    avail_rand = 1'b0;
    enc_avail  = 1'b0;
    newWords(1'b0);
    act_q.delete();
    go = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checkOutput("send_busy", 32'(busy), 32'd1);
    checkOutput("send_enc_data", 32'(enc_data), 32'(words[0][7:0]));
    #1 enc_avail = 1'b1;
    #1 checkOutput("mealy_enc_start", 32'(enc_start), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_enc_start", 32'(enc_start), 32'd0);
    checkOutput("async_rst_flags", {28'd0, busy, done, lfsr_en, dec_read}, 32'd0);
    checkOutput("async_rst_enc_data", 32'(enc_data), 32'd0);
    checkOutput("async_rst_counts", {pass_cnt, fail_cnt | timeout_cnt}, 32'd0);
    go = 1'b0;
    enc_avail = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    dec_data  = 8'($urandom);
    dec_error = 1'b0;
    dec_avail = 1'b1;
    @(negedge clk);
    checkOutput("stale_dec_read", 32'(dec_read), 32'd1);
    @(posedge clk); #1;
    dec_avail = 1'b0;
    @(negedge clk);
    checkOutput("stale_dec_read_drop", 32'(dec_read), 32'd0);
    checkOutput("stale_counts", {pass_cnt, fail_cnt | timeout_cnt}, 32'd0);
    avail_rand = 1'b1;
  endtask

  // Encoder readiness varies so SEND sometimes has to hold.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (avail_rand) enc_avail = ($urandom_range(0, 3) != 0);
    end
  end

  // LFSR model: the word advances on the edge that ends an lfsr_en cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (lfsr_en) begin
        @(posedge clk); #1;
        if (lfsr_idx < 7) lfsr_idx++;
        lfsr_data = words[lfsr_idx];
      end
    end
  end

  // Loopback echo: action per enc_start, echo shown on WAIT_RX cycle 'delay'.
  initial begin : echo
    act_t a;
    logic [7:0] sent;
    bit got;
    forever begin
      @(negedge clk);
      if (enc_start && act_q.size() > 0) begin
        a = act_q.pop_front();
        sent = enc_data;
        if (!a.drop) begin
          repeat (a.delay) @(posedge clk);
          #1;
          dec_data  = sent ^ a.mask;
          dec_error = a.err;
          dec_avail = 1'b1;
          got = 1'b0;
          for (int k = 0; k < 8 && !got; k++) begin
            @(negedge clk);
            if (dec_read) got = 1'b1;
          end
          if (!got) checkOutput("echo_consumed", 32'd0, 32'd1);
          @(posedge clk); #1;
          dec_avail = 1'b0;
          dec_error = 1'b0;
        end
      end
    end
  end

  // Monitor: pops expected packets on enc_start and run results when done rises.
  initial begin : monitor
    res_t r;
    forever begin
      @(negedge clk);
      if (enc_start) begin
        start_cnt++;
        if (exp_pkt_q.size() == 0) checkOutput("enc_start_expected", 32'd0, 32'd1);
        else checkOutput("enc_data", 32'(enc_data), 32'(exp_pkt_q.pop_front()));
      end
      if (lfsr_en) lfsr_cnt++;
      if (dec_read) read_cnt++;
      if (done && !done_prev) begin
        if (exp_res_q.size() == 0) begin
          checkOutput("done_expected", 32'd0, 32'd1);
        end else begin
          r = exp_res_q.pop_front();
          checkOutput("pass_cnt", 32'(pass_cnt), 32'(r.pass));
          checkOutput("fail_cnt", 32'(fail_cnt), 32'(r.fail));
          checkOutput("timeout_cnt", 32'(timeout_cnt), 32'(r.tmo));
          checkOutput("fail_pkt", 32'(fail_pkt), 32'(r.fpkt));
          checkOutput("enc_start_pulses", 32'(start_cnt), 32'(r.starts));
          checkOutput("lfsr_en_pulses", 32'(lfsr_cnt), 32'(r.loads));
          checkOutput("busy_in_done", 32'(busy), 32'd0);
        end
      end
      done_prev = done;
    end
  end

  initial begin
    rst_n = 1'b0; go = 1'b0; abort = 1'b0;
    lfsr_data = 32'd0; enc_avail = 1'b0;
    dec_data = '0; dec_avail = 1'b0; dec_error = 1'b0;
    #3;
    checkOutput("reset_flags", {27'd0, busy, done, lfsr_en, dec_read, enc_start}, 32'd0);
    checkOutput("reset_counts", {pass_cnt, fail_cnt | timeout_cnt}, 32'd0);
    checkOutput("reset_data", {16'd0, enc_data, fail_pkt}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    applyStimulus(0);
    applyStimulus(1);
    applyStimulus(2);
    applyStimulus(3);
    runAbort();
    applyStimulus(0);
    runResetTest();
    for (int n = 0; n < 6; n++) applyStimulus(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    checkOutput("global_time_limit", 32'd0, 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] time limit reached");
  end

endmodule
